// File: rtl/riscv_test_ctrl.sv
// Test controller for a single RISC-V core: reset sequencing, LFSR stimulus,
// expected-store checking against the core's store bus, and pass/fail/timeout reporting.
module riscv_test_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     FIFO_DEPTH  = 8,
  parameter int unsigned     RST_CYCLES  = 3,
  parameter int unsigned     MAX_CYCLES  = 1024,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h0000_0064,
  parameter logic [31:0]     SEED        = 32'h1,
  localparam int unsigned    CW          = $clog2(MAX_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            core_reset,
  input  logic            mem_write,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] write_data,
  input  logic            exp_valid,
  output logic            exp_ready,
  input  logic [XLEN-1:0] exp_addr,
  input  logic [XLEN-1:0] exp_data,
  output logic [XLEN-1:0] rand_data,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [2:0]      err_code,
  output logic [CW-1:0]   cycle_count,
  output logic [15:0]     store_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0]     LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0]     LFSR_INIT  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [CW-1:0]   LAST_CYCLE = CW'(MAX_CYCLES - 1);
  localparam logic [NW-1:0]   FIFO_FULL  = NW'(FIFO_DEPTH);
  localparam logic [RW-1:0]   RST_LOAD   = RW'(RST_CYCLES - 1);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_UNEXP    = 3'd1;
  localparam logic [2:0] ERR_MISMATCH = 3'd2;
  localparam logic [2:0] ERR_EARLY    = 3'd3;
  localparam logic [2:0] ERR_VALUE    = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSTSEQ,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_e;

  state_e          state_q;
  logic            core_reset_q;
  logic            done_q;
  logic            pass_q;
  logic            fail_q;
  logic [2:0]      err_q;
  logic [CW-1:0]   cycle_q;
  logic [15:0]     store_cnt_q;
  logic [31:0]     lfsr_q;
  logic [31:0]     lfsr_d;
  logic [RW-1:0]   rst_cnt_q;

  logic [XLEN-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   rd_ptr_d;
  logic [NW-1:0]   count_q;
  logic [NW-1:0]   count_d;
  logic            exp_ready_q;
  logic            exp_ready_d;

  logic            push;
  logic            pop;
  logic            head_valid;
  logic [XLEN-1:0] head_addr;
  logic [XLEN-1:0] head_data;
  logic            run_active;
  logic            store_end;
  logic            store_pass;
  logic [2:0]      store_code;
  logic            timeout;

  assign run_active = (state_q == S_RUN);
  assign push       = exp_valid && exp_ready_q;
  assign head_valid = (count_q != '0);
  assign head_addr  = fifo_addr_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  // Store check uses the registered head only; a same-cycle push is not visible
  always_comb begin
    store_end  = 1'b0;
    store_pass = 1'b0;
    store_code = ERR_NONE;
    pop        = 1'b0;
    if (run_active && mem_write) begin
      if (alu_result == TOHOST_ADDR) begin
        store_end = 1'b1;
        if (write_data != XLEN'(1)) begin
          store_code = ERR_VALUE;
        end else if (head_valid) begin
          store_code = ERR_EARLY;
        end else begin
          store_pass = 1'b1;
        end
      end else if (!head_valid) begin
        store_end  = 1'b1;
        store_code = ERR_UNEXP;
      end else if ((alu_result != head_addr) || (write_data != head_data)) begin
        store_end  = 1'b1;
        store_code = ERR_MISMATCH;
      end else begin
        pop = 1'b1;
      end
    end
  end

  assign timeout = run_active && (cycle_q == LAST_CYCLE) && !store_end;
  assign lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + NW'(1);
    end else if (pop && !push) begin
      count_d = count_q - NW'(1);
    end
    exp_ready_d = (count_d != FIFO_FULL);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= exp_addr;
      fifo_data_q[wr_ptr_q] <= exp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      exp_ready_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      exp_ready_q <= exp_ready_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      err_q        <= ERR_NONE;
      cycle_q      <= '0;
      store_cnt_q  <= '0;
      lfsr_q       <= LFSR_INIT;
      rst_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_PASS, S_FAIL: begin
          if (start) begin
            state_q      <= S_RSTSEQ;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_q        <= ERR_NONE;
            cycle_q      <= '0;
            store_cnt_q  <= '0;
            lfsr_q       <= LFSR_INIT;
            rst_cnt_q    <= RST_LOAD;
          end
        end
        S_RSTSEQ: begin
          if (rst_cnt_q == '0) begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q - RW'(1);
          end
        end
        S_RUN: begin
          cycle_q <= cycle_q + CW'(1);
          lfsr_q  <= lfsr_d;
          if (pop && (store_cnt_q != 16'hFFFF)) begin
            store_cnt_q <= store_cnt_q + 16'd1;
          end
          if (store_end) begin
            state_q      <= store_pass ? S_PASS : S_FAIL;
            core_reset_q <= 1'b1;
            done_q       <= 1'b1;
            pass_q       <= store_pass;
            fail_q       <= !store_pass;
            err_q        <= store_code;
          end else if (timeout) begin
            state_q      <= S_FAIL;
            core_reset_q <= 1'b1;
            done_q       <= 1'b1;
            fail_q       <= 1'b1;
            err_q        <= ERR_TIMEOUT;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          core_reset_q <= 1'b1;
        end
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign exp_ready   = exp_ready_q;
  assign rand_data   = XLEN'(lfsr_q);
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_q;
  assign cycle_count = cycle_q;
  assign store_count = store_cnt_q;

endmodule

// File: tb/tb_riscv_test_ctrl.sv
// Bench for riscv_test_ctrl: a queue-based behavioural model checked every cycle,
// plus directed runs with hand-computed expectations.
module tb_riscv_test_ctrl;
  localparam int          DEPTH  = 8;
  localparam int          RSTC   = 3;
  localparam int          MAXC   = 16;
  localparam logic [31:0] TOHOST = 32'h0000_0064;
  localparam int          CW     = $clog2(MAXC + 1);

  localparam int PH_IDLE = 0;
  localparam int PH_RST  = 1;
  localparam int PH_RUN  = 2;
  localparam int PH_END  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mem_write = 1'b0;
  logic          exp_valid = 1'b0;
  logic [31:0]   alu_result = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   exp_addr = '0;
  logic [31:0]   exp_data = '0;
  logic          core_reset;
  logic          exp_ready;
  logic [31:0]   rand_data;
  logic          done;
  logic          pass;
  logic          fail;
  logic [2:0]    err_code;
  logic [CW-1:0] cycle_count;
  logic [15:0]   store_count;

  int n_assert = 0;
  int n_fail   = 0;

  riscv_test_ctrl #(
    .XLEN(32), .FIFO_DEPTH(DEPTH), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
    .TOHOST_ADDR(TOHOST), .SEED(32'h1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .core_reset(core_reset),
    .mem_write(mem_write), .alu_result(alu_result), .write_data(write_data),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr), .exp_data(exp_data),
    .rand_data(rand_data), .done(done), .pass(pass), .fail(fail), .err_code(err_code),
    .cycle_count(cycle_count), .store_count(store_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: run phase, expected-store queue and result fields
  int          m_phase, m_rst_left, m_cycles, m_stores, m_err;
  bit          m_done, m_pass, m_fail, m_ready;
  logic [31:0] m_lfsr;
  logic [63:0] m_q[$];

  function automatic logic [31:0] poly_mask();
    int exps[4] = '{32, 22, 2, 1};
    logic [31:0] m = '0;
    foreach (exps[k]) m[exps[k]-1] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ poly_mask()) : (v >> 1);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_rst_left = 0; m_cycles = 0; m_stores = 0; m_err = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_ready = 0; m_lfsr = 32'h1;
    m_q.delete();
  endtask

  task automatic model_step();
    int  code;
    bit  push;
    code = -1;
    push = exp_valid && m_ready;
    case (m_phase)
      PH_IDLE, PH_END: if (start) begin
        m_phase = PH_RST; m_rst_left = RSTC; m_lfsr = 32'h1;
        m_cycles = 0; m_stores = 0; m_done = 0; m_pass = 0; m_fail = 0; m_err = 0;
      end
      PH_RST: begin
        m_rst_left--;
        if (m_rst_left == 0) m_phase = PH_RUN;
      end
      PH_RUN: begin
        if (mem_write) begin
          if (alu_result == TOHOST) code = (write_data != 32'h1) ? 4 : (m_q.size() != 0) ? 3 : 0;
          else if (m_q.size() == 0) code = 1;
          else if (m_q[0] != {alu_result, write_data}) code = 2;
          else begin
            void'(m_q.pop_front());
            if (m_stores != 65535) m_stores++;
          end
        end
        if (code < 0 && m_cycles == MAXC - 1) code = 5;
        m_cycles++;
        m_lfsr = lfsr_step(m_lfsr);
        if (code >= 0) begin
          m_phase = PH_END; m_done = 1; m_pass = (code == 0); m_fail = (code != 0); m_err = code;
        end
      end
      default: ;
    endcase
    if (push) m_q.push_back({exp_addr, exp_data});
    m_ready = (m_q.size() != DEPTH);
  endtask

  always @(negedge clk) begin
    if (!reset) model_reset();
    chk("model.core_reset",  64'(core_reset),  64'(m_phase != PH_RUN));
    chk("model.exp_ready",   64'(exp_ready),   64'(m_ready));
    chk("model.rand_data",   64'(rand_data),   64'(m_lfsr));
    chk("model.done",        64'(done),        64'(m_done));
    chk("model.pass",        64'(pass),        64'(m_pass));
    chk("model.fail",        64'(fail),        64'(m_fail));
    chk("model.err_code",    64'(err_code),    64'(m_err));
    chk("model.cycle_count", 64'(cycle_count), 64'(m_cycles));
    chk("model.store_count", 64'(store_count), 64'(m_stores));
    if (reset) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; alu_result = a; write_data = d;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RSTC) tick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    chk("wait_done", 64'(done), 64'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got no finish, expected finish by 20000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    #0;
    chk("rel.exp_ready0", 64'(exp_ready), 64'd0);
    tick();
    chk("rel.exp_ready1", 64'(exp_ready), 64'd1);
    chk("rel.core_reset", 64'(core_reset), 64'd1);

    // reset sequence, LFSR start, then timeout with no stores
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seq.cr0", 64'(core_reset), 64'd1);
    tick(); chk("seq.cr1", 64'(core_reset), 64'd1);
    tick(); chk("seq.cr2", 64'(core_reset), 64'd1);
    tick(); chk("seq.cr3", 64'(core_reset), 64'd0);
    chk("seq.lfsr0", 64'(rand_data), 64'h1);
    tick(); chk("seq.lfsr1", 64'(rand_data), 64'h8020_0003);
    tick(); chk("seq.lfsr2", 64'(rand_data), 64'hC030_0002);
    chk("seq.cycles", 64'(cycle_count), 64'd2);
    wait_done(30);
    chk("tmo.fail", 64'(fail), 64'd1);
    chk("tmo.err", 64'(err_code), 64'd5);
    chk("tmo.cycles", 64'(cycle_count), 64'd16);
    chk("tmo.core_reset", 64'(core_reset), 64'd1);

    // pass path
    push_exp(32'h60, 32'h7);
    push_exp(32'h54, 32'hA);
    run_start();
    store(32'h60, 32'h7);
    store(32'h54, 32'hA);
    store(TOHOST, 32'h1);
    chk("pass.store_count", 64'(store_count), 64'd2);
    chk("pass.pass", 64'(pass), 64'd1);
    chk("pass.done", 64'(done), 64'd1);
    chk("pass.err", 64'(err_code), 64'd0);

    // mismatch leaves the head in place; early tohost then sees it
    push_exp(32'h60, 32'h7);
    run_start();
    store(32'h60, 32'h8);
    chk("mism.fail", 64'(fail), 64'd1);
    chk("mism.err", 64'(err_code), 64'd2);
    run_start();
    store(TOHOST, 32'h1);
    chk("early.err", 64'(err_code), 64'd3);
    chk("early.store_count", 64'(store_count), 64'd0);
    run_start();
    store(32'h60, 32'h7);
    chk("val.running", 64'(done), 64'd0);
    store(TOHOST, 32'h5);
    chk("val.err", 64'(err_code), 64'd4);
    chk("val.store_count", 64'(store_count), 64'd1);

    // fill the FIFO, ninth push refused, pop while full admits no push
    exp_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr = 32'h100 + 32'(4 * i); exp_data = 32'(i);
      tick();
    end
    chk("full.ready", 64'(exp_ready), 64'd0);
    exp_addr = 32'h200; exp_data = 32'hDEAD;
    tick(); tick();
    chk("full.ready_held", 64'(exp_ready), 64'd0);
    exp_valid = 1'b0;
    run_start();
    exp_valid = 1'b1; exp_addr = 32'h200; exp_data = 32'h55;
    store(32'h100, 32'h0);
    exp_valid = 1'b0;
    chk("full.ready_after_pop", 64'(exp_ready), 64'd1);
    for (int i = 1; i < DEPTH; i++) store(32'h100 + 32'(4 * i), 32'(i));
    store(TOHOST, 32'h1);
    chk("full.pass", 64'(pass), 64'd1);
    chk("full.store_count", 64'(store_count), 64'd8);

    // unexpected store with empty FIFO
    run_start();
    store(32'h10, 32'h3);
    chk("unexp.err", 64'(err_code), 64'd1);
    chk("unexp.fail", 64'(fail), 64'd1);

    // asynchronous reset in the middle of a run
    run_start();
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    chk("arst.core_reset", 64'(core_reset), 64'd1);
    chk("arst.exp_ready", 64'(exp_ready), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.fail", 64'(fail), 64'd0);
    chk("arst.err", 64'(err_code), 64'd0);
    chk("arst.cycles", 64'(cycle_count), 64'd0);
    chk("arst.lfsr", 64'(rand_data), 64'h1);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("arst.ready_back", 64'(exp_ready), 64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_test_ctrl.md
Name: riscv_test_ctrl

Overview:
Synthesizable, parametrised test controller for RISC-V cores; next generation of the single-core test bench flow. Generates the core reset sequence and an LFSR stimulus word. Buffers expected data-memory stores in a FIFO and checks the core's store bus against them. Detects the tohost pass write and a cycle timeout, then reports pass/fail with an error code. Sits between the core's data-memory port and bench/FPGA top.

Parameters:
XLEN, 32, address/data width of the monitored store bus
FIFO_DEPTH, 8, expected-store FIFO entries; power of 2, >=2
RST_CYCLES, 3, cycles core_reset is held high after start
MAX_CYCLES, 1024, RUN-state cycle budget before timeout
TOHOST_ADDR, 32'h0000_0064, store address that ends the test
SEED, 32'h1, LFSR seed; value 0 is replaced by 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low harness reset
start  in  1  level; sampled in IDLE/PASS/FAIL to begin a run
core_reset  out  1  active-high reset to the core under test
mem_write  in  1  core store strobe
alu_result  in  XLEN  core store address
write_data  in  XLEN  core store data
exp_valid  in  1  expected-store push request
exp_ready  out  1  FIFO can accept; equals !full, registered
exp_addr  in  XLEN  expected store address
exp_data  in  XLEN  expected store data
rand_data  out  XLEN  LFSR stimulus word
done  out  1  run finished (PASS or FAIL)
pass  out  1  run passed
fail  out  1  run failed
err_code  out  3  0 none, 1 unexpected store, 2 mismatch, 3 tohost with FIFO non-empty, 4 tohost value != 1, 5 timeout
cycle_count  out  $clog2(MAX_CYCLES+1)  cycles spent in RUN
store_count  out  16  matched stores; saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, async): state IDLE; core_reset=1, exp_ready=0, done=pass=fail=0, err_code=0, counters 0, FIFO emptied, LFSR=SEED (or 1). exp_ready becomes 1 on the first clock after deassertion.
- FSM IDLE -> RSTSEQ -> RUN -> PASS|FAIL.
  - IDLE: core_reset=1; start=1 -> RSTSEQ.
  - RSTSEQ: core_reset=1 for exactly RST_CYCLES cycles -> RUN. Clears cycle_count and store_count.
  - RUN: core_reset=0; cycle_count increments every cycle.
  - PASS/FAIL: core_reset=1, done=1, result held. start=1 -> RSTSEQ, clearing pass/fail/err_code. FIFO is not cleared.
- FIFO push when exp_valid && exp_ready, in any state. exp_ready=!full is registered: a pop while full does not permit a push in the same cycle.
- RUN store check, evaluated only when mem_write=1, against the registered FIFO head. No bypass of a same-cycle push.
  - alu_result==TOHOST_ADDR: write_data!=1 -> FAIL code 4; else FIFO non-empty -> FAIL code 3; else PASS.
  - Other address, FIFO empty: FAIL code 1.
  - Head mismatch on address or data: FAIL code 2; head is not popped.
  - Match: pop; store_count++.
- Timeout: in RUN, when cycle_count==MAX_CYCLES-1 and no store outcome that cycle -> FAIL code 5. A store outcome in the same cycle takes priority.
- State and result outputs update one clock after the deciding cycle. A matched pop takes effect the same edge.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1, truncated/zero-extended to XLEN. Advances once per RUN cycle, holds otherwise, reloads SEED on entering RSTSEQ.

Test Plan:
- Reset/sequence: release reset, pulse start -> core_reset high for exactly 3 cycles after start is sampled, then low; exp_ready=1 one cycle after release.
- Pass path: push (0x60,0x7),(0x54,0xA); core stores them in order, then 0x1 to 0x64 -> store_count=2, pass=1, done=1, err_code=0.
- Mismatch: push (0x60,0x7); core stores 0x8 to 0x60 -> fail=1, err_code=2, FIFO still holds 1 entry.
- Early tohost and bad value: one expected entry pending, store 1 to 0x64 -> err_code=3; separate run with empty FIFO storing 5 to 0x64 -> err_code=4.
- Full/unexpected: push 8 entries -> exp_ready=0 with exp_valid held, 9th not accepted; empty FIFO plus store to 0x10 -> err_code=1.
- Timeout/async reset: MAX_CYCLES=16, no stores -> fail with err_code=5 after 16 RUN cycles; assert reset mid-RUN -> all outputs return to reset values immediately, without waiting for clk.
